hazard_stall_controller: RTL
============================

Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage datapath (IF/ID/EX/MEM/WB).
- Generates PC and pipeline-register write enables, bubble inserts and flushes for three cases: load-use hazards, taken branches resolved in MEM, and a multi-cycle MDU op (mul/SAD accumulate) that occupies EX for MDU_LATENCY cycles.
- Sits beside the top-level datapath, driving the enables of ProgramCounter, IF_ID_REG, ID_EX_REG and EX_MEM_REG.
- Includes saturating performance counters.

Parameters:
- MDU_LATENCY, 4, total EX-stage cycles of an MDU op; legal range 1..16; 1 means no stall.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_is_mdu  in  1  ID instruction is a multi-cycle MDU op.
- ex_memRead  in  1  EX instruction is a load.
- ex_regWrite  in  1  EX instruction writes a register.
- ex_writeReg  in  5  EX destination register.
- mem_branch  in  1  MEM instruction is a branch.
- mem_zero  in  1  zero flag latched in EX/MEM.
- pc_write  out  1  PC load enable.
- pc_src  out  1  1 selects the branch target.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_write  out  1  ID/EX load enable.
- id_ex_bubble  out  1  ID/EX loads with controls zeroed.
- ex_mem_bubble  out  1  EX/MEM loads with controls zeroed.
- mdu_busy  out  1  high while in MDU_WAIT.
- stall_cycles  out  CNT_W  cycles with pc_write=0, saturating.
- flush_count  out  CNT_W  taken branches, saturating.

Behaviour:
- Derived terms:
  - taken = mem_branch & mem_zero.
  - lu = ex_memRead & ex_regWrite & (ex_writeReg != 0) & ((id_uses_rs & id_rs == ex_writeReg) | (id_uses_rt & id_rt == ex_writeReg)).
- State register: {RUN, MDU_WAIT} plus a 4-bit down-counter cnt.
  - Reset (rst=0, asynchronous): state=RUN, cnt=0, stall_cycles=0, flush_count=0.
  - Outputs are combinational from state and inputs, so in reset they take the RUN/idle values: pc_write=1, if_id_write=1, id_ex_write=1, all other 1-bit outputs 0.
- Priority, highest first: taken > MDU_WAIT > lu > MDU entry.
- RUN with taken:
  - pc_write=1, pc_src=1, if_id_flush=1, id_ex_bubble=1, ex_mem_bubble=1.
  - No MDU entry even if id_is_mdu=1; the instruction in ID is squashed.
  - flush_count increments.
- RUN with !taken & lu:
  - pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly one cycle. The stall is self-clearing because the load moves to MEM.
  - No MDU entry.
- RUN with !taken & !lu & id_is_mdu & MDU_LATENCY>1:
  - Normal advance this cycle.
  - Next state=MDU_WAIT, cnt loaded with MDU_LATENCY-1.
- MDU_WAIT:
  - pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1. The MDU op is held in EX and bubbles drain into MEM.
  - cnt decrements each cycle. When cnt==1, next state=RUN, so the stall lasts exactly MDU_LATENCY-1 cycles and the op leaves EX on the following cycle.
  - lu is ignored in MDU_WAIT.
- Taken while in MDU_WAIT: possible only in the first wait cycle, when the older branch is in MEM.
  - The MDU op is younger and is squashed: apply the taken outputs, then next state=RUN and cnt=0.
- Counters:
  - stall_cycles increments on every cycle with pc_write=0 and holds at all-ones.
  - flush_count increments on every cycle with taken and holds at all-ones.
- Reset asserted mid-MDU_WAIT: state returns to RUN immediately (asynchronously); counters clear.

Test Plan:
- Load-use: EX lw $8, ID add reading rs=8 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle all enables 1; stall_cycles=1.
- Zero-register exemption: lw $0 in EX, ID uses rs=0 -> no stall, pc_write=1.
- MDU, MDU_LATENCY=4: id_is_mdu pulse -> mdu_busy high for 3 cycles with id_ex_write=0 and ex_mem_bubble=1; stall_cycles=3; state RUN on the 4th cycle.
- Taken branch: mem_branch=1, mem_zero=1 -> pc_src=1, if_id_flush=1, id_ex_bubble=1, ex_mem_bubble=1 in one cycle; flush_count=1. With mem_zero=0 -> no flush.
- Simultaneous events:
  - taken in the first MDU_WAIT cycle -> flush outputs, mdu_busy drops the next cycle.
  - taken with id_is_mdu in RUN -> MDU_WAIT never entered.
  - lu with id_is_mdu -> one-cycle stall and no entry that cycle.
- Reset and saturation:
  - rst low mid-MDU_WAIT -> mdu_busy=0 and counters=0 immediately.
  - CNT_W=4 with 20 stall cycles -> stall_cycles holds at 15.

Source files
------------

// File: rtl/hazard_stall_controller_if.sv
// Control bundle between the pipeline datapath and the hazard/stall controller.
// The datapath side takes the master modport; the controller takes the slave modport.
interface hazard_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_is_mdu;
  logic             ex_memRead;
  logic             ex_regWrite;
  logic [4:0]       ex_writeReg;
  logic             mem_branch;
  logic             mem_zero;
  logic             pc_write;
  logic             pc_src;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_bubble;
  logic             ex_mem_bubble;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mdu,
           ex_memRead, ex_regWrite, ex_writeReg, mem_branch, mem_zero,
    input  pc_write, pc_src, if_id_write, if_id_flush, id_ex_write,
           id_ex_bubble, ex_mem_bubble, mdu_busy, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mdu,
           ex_memRead, ex_regWrite, ex_writeReg, mem_branch, mem_zero,
    output pc_write, pc_src, if_id_write, if_id_flush, id_ex_write,
           id_ex_bubble, ex_mem_bubble, mdu_busy, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Five-stage pipeline sequencer: resolves load-use stalls, taken-branch flushes and
// multi-cycle MDU occupancy of EX, with saturating stall/flush performance counters.
module hazard_stall_controller #(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input logic                  clk,
  input logic                  rst,
  hazard_stall_controller_if.slave bus
);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  localparam logic [3:0] MDU_WAIT_LOAD = 4'(MDU_LATENCY - 1);

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  logic w_taken;
  logic w_lu;
  logic w_rs_hit;
  logic w_rt_hit;

  assign w_taken  = bus.mem_branch & bus.mem_zero;
  assign w_rs_hit = bus.id_uses_rs & (bus.id_rs == bus.ex_writeReg);
  assign w_rt_hit = bus.id_uses_rt & (bus.id_rt == bus.ex_writeReg);
  assign w_lu     = bus.ex_memRead & bus.ex_regWrite & (bus.ex_writeReg != 5'd0)
                  & (w_rs_hit | w_rt_hit);

  // Priority: taken branch > MDU hold > load-use > MDU entry.
  always_comb begin
    // NOTE: every output gets its idle value first so no path leaves one unassigned (no latch).
    bus.pc_write      = 1'b1;
    bus.pc_src        = 1'b0;
    bus.if_id_write   = 1'b1;
    bus.if_id_flush   = 1'b0;
    bus.id_ex_write   = 1'b1;
    bus.id_ex_bubble  = 1'b0;
    bus.ex_mem_bubble = 1'b0;
    if (w_taken) begin
      bus.pc_src        = 1'b1;
      bus.if_id_flush   = 1'b1;
      bus.id_ex_bubble  = 1'b1;
      bus.ex_mem_bubble = 1'b1;
    end else if (r_state == MDU_WAIT) begin
      bus.pc_write      = 1'b0;
      bus.if_id_write   = 1'b0;
      bus.id_ex_write   = 1'b0;
      bus.ex_mem_bubble = 1'b1;
    end else if (w_lu) begin
      bus.pc_write      = 1'b0;
      bus.if_id_write   = 1'b0;
      bus.id_ex_bubble  = 1'b1;
    end
  end

  assign bus.mdu_busy     = (r_state == MDU_WAIT);
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_count  = r_flush_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= RUN;
      r_cnt          <= 4'd0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      if (w_taken) begin
        // A younger MDU op in EX is squashed together with the rest of the wrong path.
        r_state <= RUN;
        r_cnt   <= 4'd0;
      end else if (r_state == MDU_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) r_state <= RUN;
      end else if (!w_lu && bus.id_is_mdu && (MDU_LATENCY > 1)) begin
        r_state <= MDU_WAIT;
        r_cnt   <= MDU_WAIT_LOAD;
      end

      if (!bus.pc_write && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_taken && (r_flush_count != '1))       r_flush_count  <= r_flush_count + 1'b1;
    end
  end

endmodule
